// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared encodings for the hardwired control unit of the 32-bit, 16-register
// datapath: instruction opcodes (ir[31:27]), ALU operation codes, the
// sequencer state encoding and the instruction classes produced by the
// opcode classifier.
// No ports (package).
// ----------------------------------------------------------------------------
package cpu_pkg;

    // Opcodes as they appear in ir[31:27]
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10101;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // The ALU reuses the arithmetic opcodes as its operation codes, so an
    // address or PC increment is simply the add opcode.
    localparam logic [4:0] ALU_NONE = 5'b00000;
    localparam logic [4:0] ALU_ADD  = OP_ADD;

    // Sequencer states
    typedef enum logic [3:0] {
        ST_RST   = 4'd0,
        ST_F0    = 4'd1,
        ST_F1    = 4'd2,
        ST_F2    = 4'd3,
        ST_T3    = 4'd4,
        ST_T4    = 4'd5,
        ST_T5    = 4'd6,
        ST_T6    = 4'd7,
        ST_T7    = 4'd8,
        ST_PAUSE = 4'd9,
        ST_HALT  = 4'd10
    } state_t;

    // Instruction classes; every opcode that is not listed maps to CLS_NOP
    typedef enum logic [3:0] {
        CLS_RTYPE = 4'd0,
        CLS_IMM   = 4'd1,
        CLS_LD    = 4'd2,
        CLS_LDI   = 4'd3,
        CLS_ST    = 4'd4,
        CLS_BR    = 4'd5,
        CLS_JR    = 4'd6,
        CLS_NOP   = 4'd7,
        CLS_HALT  = 4'd8
    } instr_class_t;

endpackage

// File: rtl/opcode_classifier.sv
// ----------------------------------------------------------------------------
// opcode_classifier
// Purely combinational: maps the 5-bit opcode to an instruction class so the
// sequencer only has to reason about nine behaviours instead of 32 codes.
// Ports:
//   opcode_i  in  5  ir[31:27]
//   class_o   out 4  instr_class_t encoding (see cpu_pkg)
// ----------------------------------------------------------------------------
module opcode_classifier
    import cpu_pkg::*;
(
    input  logic [4:0] opcode_i,
    output logic [3:0] class_o
);

    instr_class_t instrClass;

    // Group opcodes by the sequence of timing states they need; anything
    // unrecognised is treated as a nop so a bad fetch cannot wedge the FSM.
    always_comb begin
        instrClass = CLS_NOP;
        case (opcode_i)
            OP_ADD, OP_SUB, OP_AND, OP_OR: instrClass = CLS_RTYPE;
            OP_ADDI, OP_ANDI, OP_ORI:      instrClass = CLS_IMM;
            OP_LD:                         instrClass = CLS_LD;
            OP_LDI:                        instrClass = CLS_LDI;
            OP_ST:                         instrClass = CLS_ST;
            OP_BR:                         instrClass = CLS_BR;
            OP_JR:                         instrClass = CLS_JR;
            OP_HALT:                       instrClass = CLS_HALT;
            default:                       instrClass = CLS_NOP;
        endcase
    end

    assign class_o = instrClass;

endmodule

// File: rtl/control_sequencer.sv
// ----------------------------------------------------------------------------
// control_sequencer
// Hardwired Moore control unit: fetches each instruction, decodes ir[31:27]
// and steps through the timing states of that instruction, driving the
// register-select strobes, datapath enables, ALU op and memory strobes.
// Ports:
//   clock, reset_n               clock (rising edge), async active-low reset
//   ir[31:0]                     instruction register (opcode in [31:27])
//   con_ff, mem_ready, stop      branch flag, memory done, pause request
//   gra grb grc rin rout baout   register-select controls
//   pc_out pc_in inc_pc mar_in mdr_in mdr_out ir_in y_in z_in zlow_out
//   c_out con_in                 datapath enables
//   alu_op[4:0]                  ALU operation
//   read, write                  memory strobes
//   run                          high while executing (F0..T7)
// ----------------------------------------------------------------------------
module control_sequencer
    import cpu_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        mem_ready,
    input  logic        stop,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        rin,
    output logic        rout,
    output logic        baout,
    output logic        pc_out,
    output logic        pc_in,
    output logic        inc_pc,
    output logic        mar_in,
    output logic        mdr_in,
    output logic        mdr_out,
    output logic        ir_in,
    output logic        y_in,
    output logic        z_in,
    output logic        zlow_out,
    output logic        c_out,
    output logic        con_in,
    output logic [4:0]  alu_op,
    output logic        read,
    output logic        write,
    output logic        run
);

    state_t       state_q;
    state_t       state_d;
    state_t       endNext;
    instr_class_t instrClass;
    logic [3:0]   classBits;
    logic         unusedIrBits;

    // Only the opcode field steers the sequencer; register fields go straight
    // to the select/encode stage elsewhere.
    assign unusedIrBits = ^ir[26:0];

    opcode_classifier u_classifier (
        .opcode_i (ir[31:27]),
        .class_o  (classBits)
    );

    assign instrClass = instr_class_t'(classBits);

    // State register; reset forces RST so every output drops at once,
    // even in the middle of a memory wait.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Transition logic. endNext is where the last state of every instruction
    // goes, which is the only place stop is looked at. States reached with a
    // class that has no business there fall back to F0 rather than hanging.
    always_comb begin
        state_d = state_q;
        endNext = stop ? ST_PAUSE : ST_F0;
        case (state_q)
            ST_RST: state_d = ST_F0;
            ST_F0:  state_d = ST_F1;
            ST_F1:  if (mem_ready) state_d = ST_F2;
            ST_F2: begin
                case (instrClass)
                    CLS_HALT: state_d = ST_HALT;
                    CLS_NOP:  state_d = endNext;
                    default:  state_d = ST_T3;
                endcase
            end
            ST_T3: begin
                case (instrClass)
                    CLS_JR:                                   state_d = endNext;
                    CLS_RTYPE, CLS_IMM, CLS_LD, CLS_LDI,
                    CLS_ST, CLS_BR:                           state_d = ST_T4;
                    default:                                  state_d = ST_F0;
                endcase
            end
            ST_T4: begin
                case (instrClass)
                    CLS_RTYPE, CLS_IMM, CLS_LD, CLS_LDI,
                    CLS_ST, CLS_BR:                           state_d = ST_T5;
                    default:                                  state_d = ST_F0;
                endcase
            end
            ST_T5: begin
                case (instrClass)
                    CLS_RTYPE, CLS_IMM, CLS_LDI: state_d = endNext;
                    CLS_LD, CLS_ST, CLS_BR:      state_d = ST_T6;
                    default:                     state_d = ST_F0;
                endcase
            end
            ST_T6: begin
                case (instrClass)
                    CLS_LD:  state_d = mem_ready ? ST_T7 : ST_T6;
                    CLS_ST:  state_d = ST_T7;
                    CLS_BR:  state_d = endNext;
                    default: state_d = ST_F0;
                endcase
            end
            ST_T7: begin
                case (instrClass)
                    CLS_LD:  state_d = endNext;
                    CLS_ST:  state_d = mem_ready ? endNext : ST_T7;
                    default: state_d = ST_F0;
                endcase
            end
            ST_PAUSE: if (!stop) state_d = ST_F0;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_RST;
        endcase
    end

    // Output decode from state and instruction class. Everything defaults
    // low, so RST, PAUSE and HALT need no explicit arm. con_ff is consulted
    // only in the branch T6 state to decide whether the target is loaded.
    always_comb begin
        gra      = 1'b0;
        grb      = 1'b0;
        grc      = 1'b0;
        rin      = 1'b0;
        rout     = 1'b0;
        baout    = 1'b0;
        pc_out   = 1'b0;
        pc_in    = 1'b0;
        inc_pc   = 1'b0;
        mar_in   = 1'b0;
        mdr_in   = 1'b0;
        mdr_out  = 1'b0;
        ir_in    = 1'b0;
        y_in     = 1'b0;
        z_in     = 1'b0;
        zlow_out = 1'b0;
        c_out    = 1'b0;
        con_in   = 1'b0;
        alu_op   = ALU_NONE;
        read     = 1'b0;
        write    = 1'b0;
        run      = 1'b0;
        case (state_q)
            ST_F0: begin
                run = 1'b1; pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1;
                z_in = 1'b1; alu_op = ALU_ADD;
            end
            ST_F1: begin
                run = 1'b1; zlow_out = 1'b1; pc_in = 1'b1; read = 1'b1;
                mdr_in = 1'b1;
            end
            ST_F2: begin
                run = 1'b1; mdr_out = 1'b1; ir_in = 1'b1;
            end
            ST_T3: begin
                run = 1'b1;
                case (instrClass)
                    CLS_RTYPE, CLS_IMM: begin
                        grb = 1'b1; rout = 1'b1; y_in = 1'b1;
                    end
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        grb = 1'b1; baout = 1'b1; y_in = 1'b1;
                    end
                    CLS_BR: begin
                        gra = 1'b1; rout = 1'b1; con_in = 1'b1;
                    end
                    CLS_JR: begin
                        gra = 1'b1; rout = 1'b1; pc_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                run = 1'b1;
                case (instrClass)
                    CLS_RTYPE: begin
                        grc = 1'b1; rout = 1'b1; z_in = 1'b1; alu_op = ir[31:27];
                    end
                    CLS_IMM: begin
                        c_out = 1'b1; z_in = 1'b1; alu_op = ir[31:27];
                    end
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        c_out = 1'b1; z_in = 1'b1; alu_op = ALU_ADD;
                    end
                    CLS_BR: begin
                        pc_out = 1'b1; y_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                run = 1'b1;
                case (instrClass)
                    CLS_RTYPE, CLS_IMM, CLS_LDI: begin
                        zlow_out = 1'b1; gra = 1'b1; rin = 1'b1;
                    end
                    CLS_LD, CLS_ST: begin
                        zlow_out = 1'b1; mar_in = 1'b1;
                    end
                    CLS_BR: begin
                        c_out = 1'b1; z_in = 1'b1; alu_op = ALU_ADD;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                run = 1'b1;
                case (instrClass)
                    CLS_LD: begin
                        read = 1'b1; mdr_in = 1'b1;
                    end
                    CLS_ST: begin
                        gra = 1'b1; rout = 1'b1; mdr_in = 1'b1;
                    end
                    CLS_BR: begin
                        zlow_out = con_ff; pc_in = con_ff;
                    end
                    default: ;
                endcase
            end
            ST_T7: begin
                run = 1'b1;
                case (instrClass)
                    CLS_LD: begin
                        mdr_out = 1'b1; gra = 1'b1; rin = 1'b1;
                    end
                    CLS_ST: write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// ----------------------------------------------------------------------------
// tb_control_sequencer
// Self-checking bench for control_sequencer. All outputs are packed into one
// 26-bit word; each cycle's expected word is queued when the cycle's inputs
// are driven and popped/compared on the following falling edge.
// ----------------------------------------------------------------------------
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] ir;
    logic        con_ff, mem_ready, stop;
    logic        gra, grb, grc, rin, rout, baout;
    logic        pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in;
    logic        y_in, z_in, zlow_out, c_out, con_in;
    logic [4:0]  alu_op;
    logic        read, write, run;
    logic [25:0] obs;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [25:0] expQ[$];
    string       tagQ[$];

    // Bit positions within the packed output word
    localparam logic [25:0] B_RUN    = 26'h1 << 0;
    localparam logic [25:0] B_WRITE  = 26'h1 << 1;
    localparam logic [25:0] B_READ   = 26'h1 << 2;
    localparam logic [25:0] B_CONIN  = 26'h1 << 8;
    localparam logic [25:0] B_COUT   = 26'h1 << 9;
    localparam logic [25:0] B_ZLOW   = 26'h1 << 10;
    localparam logic [25:0] B_ZIN    = 26'h1 << 11;
    localparam logic [25:0] B_YIN    = 26'h1 << 12;
    localparam logic [25:0] B_IRIN   = 26'h1 << 13;
    localparam logic [25:0] B_MDROUT = 26'h1 << 14;
    localparam logic [25:0] B_MDRIN  = 26'h1 << 15;
    localparam logic [25:0] B_MARIN  = 26'h1 << 16;
    localparam logic [25:0] B_INCPC  = 26'h1 << 17;
    localparam logic [25:0] B_PCIN   = 26'h1 << 18;
    localparam logic [25:0] B_PCOUT  = 26'h1 << 19;
    localparam logic [25:0] B_BAOUT  = 26'h1 << 20;
    localparam logic [25:0] B_ROUT   = 26'h1 << 21;
    localparam logic [25:0] B_RIN    = 26'h1 << 22;
    localparam logic [25:0] B_GRC    = 26'h1 << 23;
    localparam logic [25:0] B_GRB    = 26'h1 << 24;
    localparam logic [25:0] B_GRA    = 26'h1 << 25;
    localparam logic [25:0] A_ADD    = 26'd3 << 3;

    // Fetch and shared timing-state words
    localparam logic [25:0] W_F0 = B_RUN | B_PCOUT | B_MARIN | B_INCPC | B_ZIN | A_ADD;
    localparam logic [25:0] W_F1 = B_RUN | B_ZLOW | B_PCIN | B_READ | B_MDRIN;
    localparam logic [25:0] W_F2 = B_RUN | B_MDROUT | B_IRIN;
    localparam logic [25:0] W_R3 = B_RUN | B_GRB | B_ROUT | B_YIN;
    localparam logic [25:0] W_R5 = B_RUN | B_ZLOW | B_GRA | B_RIN;
    localparam logic [25:0] W_A3 = B_RUN | B_GRB | B_BAOUT | B_YIN;
    localparam logic [25:0] W_A4 = B_RUN | B_COUT | B_ZIN | A_ADD;
    localparam logic [25:0] W_M5 = B_RUN | B_ZLOW | B_MARIN;
    localparam logic [25:0] W_LD6 = B_RUN | B_READ | B_MDRIN;
    localparam logic [25:0] W_LD7 = B_RUN | B_MDROUT | B_GRA | B_RIN;
    localparam logic [25:0] W_ST6 = B_RUN | B_GRA | B_ROUT | B_MDRIN;
    localparam logic [25:0] W_ST7 = B_RUN | B_WRITE;
    localparam logic [25:0] W_OFF = 26'd0;

    typedef struct {
        string            name;
        logic [31:0]      ir;
        logic             con;
        int               n;
        logic [7:0][25:0] exp;
    } vec_t;

    vec_t vecs[$];

    control_sequencer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .ir        (ir),
        .con_ff    (con_ff),
        .mem_ready (mem_ready),
        .stop      (stop),
        .gra       (gra),
        .grb       (grb),
        .grc       (grc),
        .rin       (rin),
        .rout      (rout),
        .baout     (baout),
        .pc_out    (pc_out),
        .pc_in     (pc_in),
        .inc_pc    (inc_pc),
        .mar_in    (mar_in),
        .mdr_in    (mdr_in),
        .mdr_out   (mdr_out),
        .ir_in     (ir_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .zlow_out  (zlow_out),
        .c_out     (c_out),
        .con_in    (con_in),
        .alu_op    (alu_op),
        .read      (read),
        .write     (write),
        .run       (run)
    );

    assign obs = {gra, grb, grc, rin, rout, baout,
                  pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in,
                  y_in, z_in, zlow_out, c_out, con_in,
                  alu_op, read, write, run};

    // 10-unit clock
    always #5 clock = ~clock;

    // Hard stop in case the sequence ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [25:0] aluW(input logic [4:0] op);
        return {18'd0, op, 3'd0};
    endfunction

    // Instruction word with ra=1, rb=2, rc=3
    function automatic logic [31:0] mkIr(input logic [4:0] op);
        return {op, 4'd1, 4'd2, 4'd3, 15'd0};
    endfunction

    function automatic vec_t mkVec(input string nm, input logic [4:0] op,
                                   input logic con, input int n,
                                   input logic [25:0] t3, input logic [25:0] t4,
                                   input logic [25:0] t5, input logic [25:0] t6,
                                   input logic [25:0] t7);
        vec_t v;
        v.name = nm;
        v.ir   = mkIr(op);
        v.con  = con;
        v.n    = n;
        v.exp  = '0;
        v.exp[0] = W_F0;
        v.exp[1] = W_F1;
        v.exp[2] = W_F2;
        v.exp[3] = t3;
        v.exp[4] = t4;
        v.exp[5] = t5;
        v.exp[6] = t6;
        v.exp[7] = t7;
        return v;
    endfunction

    function automatic void compareWord(input string tag, input logic [25:0] got,
                                        input logic [25:0] want);
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %07h, expected %07h", tag, got, want);
        end
    endfunction

    // Pop the oldest expectation and compare against the current outputs
    task automatic checkOutput();
        logic [25:0] e;
        string       t;
        @(negedge clock);
        if (expQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL scoreboard: no expectation queued, got %07h", obs);
        end else begin
            e = expQ.pop_front();
            t = tagQ.pop_front();
            compareWord(t, obs, e);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge and queue the
    // expected output word for that cycle
    task automatic applyStimulus(input string tag, input logic rstV,
                                 input logic [31:0] irV, input logic conV,
                                 input logic mrV, input logic stopV,
                                 input logic [25:0] expV);
        @(posedge clock);
        #1;
        reset_n   = rstV;
        ir        = irV;
        con_ff    = conV;
        mem_ready = mrV;
        stop      = stopV;
        expQ.push_back(expV);
        tagQ.push_back(tag);
        checkOutput();
    endtask

    initial begin
        vec_t       v;
        int         readCount;
        logic [31:0] irLd, irSt, irAddi, irNop, irHalt;
        logic [25:0] ldSeq[11];
        logic        ldMr[11];

        reset_n = 1'b0; ir = '0; con_ff = 1'b0; mem_ready = 1'b0; stop = 1'b0;

        vecs.push_back(mkVec("add",  5'b00011, 1'b0, 6, W_R3, B_RUN|B_GRC|B_ROUT|B_ZIN|aluW(5'b00011), W_R5, W_OFF, W_OFF));
        vecs.push_back(mkVec("sub",  5'b00100, 1'b0, 6, W_R3, B_RUN|B_GRC|B_ROUT|B_ZIN|aluW(5'b00100), W_R5, W_OFF, W_OFF));
        vecs.push_back(mkVec("and",  5'b00101, 1'b0, 6, W_R3, B_RUN|B_GRC|B_ROUT|B_ZIN|aluW(5'b00101), W_R5, W_OFF, W_OFF));
        vecs.push_back(mkVec("or",   5'b00110, 1'b0, 6, W_R3, B_RUN|B_GRC|B_ROUT|B_ZIN|aluW(5'b00110), W_R5, W_OFF, W_OFF));
        vecs.push_back(mkVec("addi", 5'b01100, 1'b0, 6, W_R3, B_RUN|B_COUT|B_ZIN|aluW(5'b01100), W_R5, W_OFF, W_OFF));
        vecs.push_back(mkVec("andi", 5'b01101, 1'b0, 6, W_R3, B_RUN|B_COUT|B_ZIN|aluW(5'b01101), W_R5, W_OFF, W_OFF));
        vecs.push_back(mkVec("ori",  5'b01110, 1'b0, 6, W_R3, B_RUN|B_COUT|B_ZIN|aluW(5'b01110), W_R5, W_OFF, W_OFF));
        vecs.push_back(mkVec("ldi",  5'b00001, 1'b0, 6, W_A3, W_A4, W_R5, W_OFF, W_OFF));
        vecs.push_back(mkVec("ld",   5'b00000, 1'b0, 8, W_A3, W_A4, W_M5, W_LD6, W_LD7));
        vecs.push_back(mkVec("st",   5'b00010, 1'b0, 8, W_A3, W_A4, W_M5, W_ST6, W_ST7));
        vecs.push_back(mkVec("br_c0", 5'b10011, 1'b0, 7, B_RUN|B_GRA|B_ROUT|B_CONIN, B_RUN|B_PCOUT|B_YIN, B_RUN|B_COUT|B_ZIN|A_ADD, B_RUN, W_OFF));
        vecs.push_back(mkVec("br_c1", 5'b10011, 1'b1, 7, B_RUN|B_GRA|B_ROUT|B_CONIN, B_RUN|B_PCOUT|B_YIN, B_RUN|B_COUT|B_ZIN|A_ADD, B_RUN|B_ZLOW|B_PCIN, W_OFF));
        vecs.push_back(mkVec("jr",   5'b10101, 1'b0, 4, B_RUN|B_GRA|B_ROUT|B_PCIN, W_OFF, W_OFF, W_OFF, W_OFF));
        vecs.push_back(mkVec("nop",  5'b11010, 1'b0, 3, W_OFF, W_OFF, W_OFF, W_OFF, W_OFF));
        vecs.push_back(mkVec("undef", 5'b11111, 1'b0, 3, W_OFF, W_OFF, W_OFF, W_OFF, W_OFF));

        irLd   = mkIr(5'b00000);
        irSt   = mkIr(5'b00010);
        irAddi = mkIr(5'b01100);
        irNop  = mkIr(5'b11010);
        irHalt = mkIr(5'b11011);

        // Reset state, then release; the cycle of release is still RST
        applyStimulus("reset_a", 1'b0, '0, 1'b0, 1'b0, 1'b0, W_OFF);
        applyStimulus("reset_b", 1'b0, '0, 1'b0, 1'b0, 1'b0, W_OFF);
        applyStimulus("release", 1'b1, '0, 1'b0, 1'b1, 1'b0, W_OFF);

        // Zero-wait instructions back to back
        foreach (vecs[k]) begin
            v = vecs[k];
            for (int c = 0; c < v.n; c++) begin
                applyStimulus($sformatf("%s_c%0d", v.name, c), 1'b1, v.ir, v.con,
                              1'b1, 1'b0, v.exp[c]);
            end
        end

        // ld with three wait cycles in T6: 11 cycles, read held across the wait
        ldSeq = '{W_F0, W_F1, W_F2, W_A3, W_A4, W_M5, W_LD6, W_LD6, W_LD6, W_LD6, W_LD7};
        ldMr  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        readCount = 0;
        for (int c = 0; c < 11; c++) begin
            applyStimulus($sformatf("ldwait_c%0d", c), 1'b1, irLd, 1'b0, ldMr[c], 1'b0, ldSeq[c]);
            if (c >= 3 && read) readCount++;
        end
        testsRun++;
        if (readCount != 4) begin
            testsFailed++;
            $display("[TB] FAIL ldwait_read_cycles: got %0d, expected 4", readCount);
        end

        // stop raised in T4 of addi: completes, pauses, resumes at F0
        applyStimulus("stop_f0", 1'b1, irAddi, 1'b0, 1'b1, 1'b0, W_F0);
        applyStimulus("stop_f1", 1'b1, irAddi, 1'b0, 1'b1, 1'b0, W_F1);
        applyStimulus("stop_f2", 1'b1, irAddi, 1'b0, 1'b1, 1'b0, W_F2);
        applyStimulus("stop_t3", 1'b1, irAddi, 1'b0, 1'b1, 1'b0, W_R3);
        applyStimulus("stop_t4", 1'b1, irAddi, 1'b0, 1'b1, 1'b1, B_RUN|B_COUT|B_ZIN|aluW(5'b01100));
        applyStimulus("stop_t5", 1'b1, irAddi, 1'b0, 1'b1, 1'b1, W_R5);
        applyStimulus("pause_a", 1'b1, irAddi, 1'b0, 1'b1, 1'b1, W_OFF);
        applyStimulus("pause_b", 1'b1, irAddi, 1'b0, 1'b1, 1'b1, W_OFF);
        applyStimulus("pause_c", 1'b1, irAddi, 1'b0, 1'b1, 1'b0, W_OFF);
        applyStimulus("resume_f0", 1'b1, irNop, 1'b0, 1'b1, 1'b0, W_F0);
        applyStimulus("resume_f1", 1'b1, irNop, 1'b0, 1'b1, 1'b0, W_F1);
        applyStimulus("resume_f2", 1'b1, irNop, 1'b0, 1'b1, 1'b0, W_F2);

        // halt: everything off for 20 cycles, only reset gets out
        applyStimulus("halt_f0", 1'b1, irHalt, 1'b0, 1'b1, 1'b0, W_F0);
        applyStimulus("halt_f1", 1'b1, irHalt, 1'b0, 1'b1, 1'b0, W_F1);
        applyStimulus("halt_f2", 1'b1, irHalt, 1'b0, 1'b1, 1'b0, W_F2);
        for (int c = 0; c < 20; c++) begin
            applyStimulus($sformatf("halt_h%0d", c), 1'b1, irHalt, 1'b0, 1'b1, 1'b0, W_OFF);
        end
        applyStimulus("halt_rst", 1'b0, irSt, 1'b0, 1'b1, 1'b0, W_OFF);
        applyStimulus("halt_rel", 1'b1, irSt, 1'b0, 1'b1, 1'b0, W_OFF);

        // st stalled in T7, reset asserted mid-cycle during the wait
        applyStimulus("stw_f0", 1'b1, irSt, 1'b0, 1'b1, 1'b0, W_F0);
        applyStimulus("stw_f1", 1'b1, irSt, 1'b0, 1'b1, 1'b0, W_F1);
        applyStimulus("stw_f2", 1'b1, irSt, 1'b0, 1'b1, 1'b0, W_F2);
        applyStimulus("stw_t3", 1'b1, irSt, 1'b0, 1'b1, 1'b0, W_A3);
        applyStimulus("stw_t4", 1'b1, irSt, 1'b0, 1'b1, 1'b0, W_A4);
        applyStimulus("stw_t5", 1'b1, irSt, 1'b0, 1'b1, 1'b0, W_M5);
        applyStimulus("stw_t6", 1'b1, irSt, 1'b0, 1'b1, 1'b0, W_ST6);
        applyStimulus("stw_t7a", 1'b1, irSt, 1'b0, 1'b0, 1'b0, W_ST7);
        @(posedge clock);
        #1;
        compareWord("stw_t7b", obs, W_ST7);
        #2;
        reset_n = 1'b0;
        #1;
        compareWord("stw_async_rst", obs, W_OFF);
        applyStimulus("stw_rst_hold", 1'b0, irSt, 1'b0, 1'b0, 1'b0, W_OFF);
        applyStimulus("stw_rel", 1'b1, vecs[0].ir, 1'b0, 1'b1, 1'b0, W_OFF);
        v = vecs[0];
        for (int c = 0; c < v.n; c++) begin
            applyStimulus($sformatf("after_rst_%s_c%0d", v.name, c), 1'b1, v.ir, 1'b0,
                          1'b1, 1'b0, v.exp[c]);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
